dmem_access_ctrl: RTL and testbench

- Multi-cycle data-memory access sequencer for the MEM stage of the RV32I pipeline.
- Consumes the decoded load/store controls (mem_read, mem_write, mem_size, mem_sign) plus the ALU-computed address and store data.
- Drives a word-wide request/grant/response data bus and stalls the pipeline until the access completes.
- Generates byte enables, store-lane replication and load extraction with sign/zero extension, and reports misalignment, illegal size and bus timeout.

---
 rtl/dmem_access_ctrl_if.sv | 37 +++
 rtl/dmem_access_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_dmem_access_ctrl.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_access_ctrl_if.sv
// Pipeline-side load/store controls plus word-wide request/grant/response data bus.
// master = access sequencer, slave = pipeline/bus environment driving it.
interface dmem_access_ctrl_if;
  logic        mem_read_in;
  logic        mem_write_in;
  logic [1:0]  mem_size_in;
  logic        mem_sign_in;
  logic [31:0] addr_in;
  logic [31:0] wdata_in;
  logic        stall_out;
  logic [31:0] rdata_out;
  logic        rdata_valid;
  logic        fault_out;
  logic [1:0]  fault_code;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_gnt;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;

  modport master (
    input  mem_read_in, mem_write_in, mem_size_in, mem_sign_in, addr_in, wdata_in,
    input  bus_gnt, bus_rvalid, bus_rdata,
    output stall_out, rdata_out, rdata_valid, fault_out, fault_code,
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata
  );

  modport slave (
    output mem_read_in, mem_write_in, mem_size_in, mem_sign_in, addr_in, wdata_in,
    output bus_gnt, bus_rvalid, bus_rdata,
    input  stall_out, rdata_out, rdata_valid, fault_out, fault_code,
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata
  );
endinterface

// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-memory sequencer: store done on cycle 3, load on cycle 4 with a zero-wait bus.
// Stalls the pipeline while the bus withholds gnt/rvalid; aborts with a timeout fault after TIMEOUT_CYCLES.
module dmem_access_ctrl #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              reset,
  dmem_access_ctrl_if.master io
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_DONE  = 3'd3,
    S_FAULT = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   addr_q, addr_d;
  logic [3:0]    be_q, be_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          we_q, we_d;
  logic [1:0]    size_q, size_d;
  logic          sign_q, sign_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [1:0]    fcode_q, fcode_d;

  logic        req_any;
  logic        illegal;
  logic        misaligned;
  logic [3:0]  be_new;
  logic [31:0] wdata_new;
  logic [31:0] shifted;
  logic [31:0] load_ext;

  // Request decode, lane steering and load extraction.
  always_comb begin
    req_any    = io.mem_read_in | io.mem_write_in;
    illegal    = (io.mem_size_in == 2'b11) | (io.mem_read_in & io.mem_write_in);
    misaligned = ((io.mem_size_in == 2'b01) & io.addr_in[0]) |
                 ((io.mem_size_in == 2'b10) & (io.addr_in[1:0] != 2'b00));
    case (io.mem_size_in)
      2'b00: begin
        be_new    = 4'b0001 << io.addr_in[1:0];
        wdata_new = {4{io.wdata_in[7:0]}};
      end
      2'b01: begin
        be_new    = io.addr_in[1] ? 4'b1100 : 4'b0011;
        wdata_new = {2{io.wdata_in[15:0]}};
      end
      default: begin
        be_new    = 4'b1111;
        wdata_new = io.wdata_in;
      end
    endcase

    shifted = io.bus_rdata >> {addr_q[1:0], 3'b000};
    case (size_q)
      2'b00:   load_ext = {{24{sign_q & shifted[7]}}, shifted[7:0]};
      2'b01:   load_ext = {{16{sign_q & shifted[15]}}, shifted[15:0]};
      default: load_ext = shifted;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      size_q  <= '0;
      sign_q  <= 1'b0;
      rdata_q <= '0;
      fcode_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      size_q  <= size_d;
      sign_q  <= sign_d;
      rdata_q <= rdata_d;
      fcode_q <= fcode_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    size_d  = size_q;
    sign_d  = sign_q;
    rdata_d = rdata_q;
    fcode_d = fcode_q;
    case (state_q)
      S_IDLE: begin
        if (req_any) begin
          if (illegal) begin
            fcode_d = 2'b11;
            state_d = S_FAULT;
          end else if (misaligned) begin
            fcode_d = 2'b01;
            state_d = S_FAULT;
          end else begin
            addr_d  = io.addr_in;
            be_d    = be_new;
            wdata_d = wdata_new;
            we_d    = io.mem_write_in;
            size_d  = io.mem_size_in;
            sign_d  = io.mem_sign_in;
            cnt_d   = '0;
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        cnt_d = cnt_q + CW'(1);
        // A handshake in the last allowed cycle beats the timeout.
        if (io.bus_gnt) begin
          state_d = we_q ? S_DONE : S_WAIT;
        end else if (cnt_q == CNT_LAST) begin
          fcode_d = 2'b10;
          state_d = S_FAULT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + CW'(1);
        if (io.bus_rvalid) begin
          rdata_d = load_ext;
          state_d = S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          fcode_d = 2'b10;
          state_d = S_FAULT;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_FAULT: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    io.stall_out   = 1'b0;
    io.bus_req     = 1'b0;
    io.bus_we      = 1'b0;
    io.bus_addr    = '0;
    io.bus_be      = '0;
    io.bus_wdata   = '0;
    io.rdata_valid = 1'b0;
    io.fault_out   = 1'b0;
    io.fault_code  = '0;
    io.rdata_out   = rdata_q;
    case (state_q)
      S_IDLE: io.stall_out = req_any;
      S_REQ: begin
        io.stall_out = 1'b1;
        io.bus_req   = 1'b1;
        io.bus_we    = we_q;
        io.bus_addr  = {addr_q[31:2], 2'b00};
        io.bus_be    = be_q;
        io.bus_wdata = wdata_q;
      end
      S_WAIT: io.stall_out = 1'b1;
      S_DONE: io.rdata_valid = ~we_q;
      S_FAULT: begin
        io.fault_out  = 1'b1;
        io.fault_code = fcode_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench: stimulus pushes expected bus/load/fault events; a negedge monitor pops and compares.
module tb_dmem_access_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  dmem_access_ctrl_if io();

  dmem_access_ctrl #(.TIMEOUT_CYCLES(8)) dut (
    .clk   (clk),
    .reset (reset),
    .io    (io)
  );

  typedef struct {
    int          kind;   // 0 bus request, 1 load result, 2 fault
    logic        we;
    logic [31:0] a;
    logic [3:0]  be;
    logic [31:0] d;
  } ev_t;

  ev_t sb[$];
  int  tests = 0;
  int  fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic push_bus(input logic we, input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
    ev_t e;
    e.kind = 0; e.we = we; e.a = a; e.be = be; e.d = d;
    sb.push_back(e);
  endtask

  task automatic push_ev(input int kind, input logic [31:0] d);
    ev_t e;
    e.kind = kind; e.we = 1'b0; e.a = '0; e.be = '0; e.d = d;
    sb.push_back(e);
  endtask

  task automatic pop_expect(input int kind, output ev_t e, output bit ok);
    tests++;
    ok = 1'b0;
    e.kind = -1; e.we = 1'b0; e.a = '0; e.be = '0; e.d = '0;
    if (sb.size() == 0) begin
      fails++;
      $display("FAIL sb_unexpected: got event kind %0d expected no event", kind);
    end else begin
      e = sb.pop_front();
      if (e.kind != kind) begin
        fails++;
        $display("FAIL sb_kind: got event kind %0d expected kind %0d", kind, e.kind);
      end else begin
        ok = 1'b1;
      end
    end
  endtask

  // Monitor: compares every bus request cycle, load completion and fault pulse.
  initial begin : monitor
    logic prev_req;
    ev_t  cur;
    ev_t  e;
    bit   ok;
    prev_req = 1'b0;
    cur.kind = 0; cur.we = 1'b0; cur.a = '0; cur.be = '0; cur.d = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_req = 1'b0;
        continue;
      end
      if (io.bus_req) begin
        if (!prev_req) begin
          pop_expect(0, e, ok);
          if (ok) cur = e;
        end
        chk("bus_we", {31'b0, io.bus_we}, {31'b0, cur.we});
        chk("bus_addr", io.bus_addr, cur.a);
        chk("bus_be", {28'b0, io.bus_be}, {28'b0, cur.be});
        chk("bus_wdata", io.bus_wdata, cur.d);
      end
      prev_req = io.bus_req;
      if (io.rdata_valid) begin
        pop_expect(1, e, ok);
        if (ok) chk("rdata_out", io.rdata_out, e.d);
      end
      if (io.fault_out) begin
        pop_expect(2, e, ok);
        if (ok) chk("fault_code", {30'b0, io.fault_code}, e.d);
      end
    end
  end

  // Issues one access and plays the bus: gnt on the gnt_at-th REQ cycle (0 = never), rvalid one cycle later.
  task automatic run_access(input string nm, input logic rd, input logic wr, input logic [1:0] sz,
                            input logic sg, input logic [31:0] a, input logic [31:0] wd,
                            input logic [31:0] rw, input int gnt_at,
                            input int exp_stall, input int exp_req, input logic exp_rv);
    int   stall_c;
    int   req_c;
    bit   ended;
    bit   gnt_prev;
    logic rv_end;
    stall_c = 0; req_c = 0; ended = 1'b0; gnt_prev = 1'b0; rv_end = 1'b0;
    @(negedge clk);
    io.mem_read_in  = rd;
    io.mem_write_in = wr;
    io.mem_size_in  = sz;
    io.mem_sign_in  = sg;
    io.addr_in      = a;
    io.wdata_in     = wd;
    io.bus_rdata    = rw;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (io.stall_out) stall_c++;
      if (io.bus_req) req_c++;
      if (!io.stall_out) begin
        ended  = 1'b1;
        rv_end = io.rdata_valid;
        io.mem_read_in  = 1'b0;
        io.mem_write_in = 1'b0;
        io.bus_gnt      = 1'b0;
        io.bus_rvalid   = 1'b0;
        break;
      end
      io.bus_rvalid = gnt_prev;
      io.bus_gnt    = io.bus_req && (req_c == gnt_at);
      gnt_prev      = io.bus_gnt && rd;
      @(negedge clk);
    end
    if (!ended) begin
      io.mem_read_in  = 1'b0;
      io.mem_write_in = 1'b0;
      io.bus_gnt      = 1'b0;
      io.bus_rvalid   = 1'b0;
    end
    chk({nm, " completes"}, {31'b0, ended}, 32'd1);
    chk({nm, " stall cycles"}, stall_c, exp_stall);
    chk({nm, " bus_req cycles"}, req_c, exp_req);
    chk({nm, " end rdata_valid"}, {31'b0, rv_end}, {31'b0, exp_rv});
  endtask

  initial begin : watchdog
    #50000;
    $display("FAIL watchdog: got no end of run expected completion before 50000ns");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    io.mem_read_in = 1'b0; io.mem_write_in = 1'b0; io.mem_size_in = 2'b00; io.mem_sign_in = 1'b0;
    io.addr_in = '0; io.wdata_in = '0; io.bus_gnt = 1'b0; io.bus_rvalid = 1'b0; io.bus_rdata = '0;

    #3;
    chk("reset bus_req", {31'b0, io.bus_req}, 32'd0);
    chk("reset stall", {31'b0, io.stall_out}, 32'd0);
    chk("reset rdata_out", io.rdata_out, 32'd0);
    chk("reset rdata_valid", {31'b0, io.rdata_valid}, 32'd0);
    chk("reset fault", {29'b0, io.fault_out, io.fault_code}, 32'd0);
    #19 reset = 1'b0;

    // Loads
    push_bus(1'b0, 32'h0000_0200, 4'b1100, 32'h0);
    push_ev(1, 32'hFFFF_8001);
    run_access("ld_h_s", 1, 0, 2'b01, 1, 32'h202, 32'h0, 32'h8001_1234, 1, 3, 1, 1);
    push_bus(1'b0, 32'h0000_0200, 4'b0010, 32'h0);
    push_ev(1, 32'h0000_00F0);
    run_access("ld_b_u", 1, 0, 2'b00, 0, 32'h201, 32'h0, 32'h0000_F000, 1, 3, 1, 1);
    push_bus(1'b0, 32'h0000_0200, 4'b0010, 32'h0);
    push_ev(1, 32'hFFFF_FFF0);
    run_access("ld_b_s", 1, 0, 2'b00, 1, 32'h201, 32'h0, 32'h0000_F000, 1, 3, 1, 1);
    push_bus(1'b0, 32'h0000_0200, 4'b1000, 32'h0);
    push_ev(1, 32'h0000_0080);
    run_access("ld_b_u_top", 1, 0, 2'b00, 0, 32'h203, 32'h0, 32'h8000_0000, 1, 3, 1, 1);
    push_bus(1'b0, 32'h0000_0300, 4'b1111, 32'h0);
    push_ev(1, 32'h1234_5678);
    run_access("ld_w", 1, 0, 2'b10, 1, 32'h300, 32'h0, 32'h1234_5678, 2, 4, 2, 1);

    // Stores; rdata_out keeps the last load result
    push_bus(1'b1, 32'h0000_0100, 4'b1000, 32'hABAB_ABAB);
    run_access("st_b", 0, 1, 2'b00, 0, 32'h103, 32'h0000_00AB, 32'h0, 1, 2, 1, 0);
    #1 chk("rdata hold after store", io.rdata_out, 32'h1234_5678);
    push_bus(1'b1, 32'h0000_0104, 4'b1100, 32'hABCD_ABCD);
    run_access("st_h", 0, 1, 2'b01, 0, 32'h106, 32'h1234_ABCD, 32'h0, 1, 2, 1, 0);
    push_bus(1'b1, 32'h0000_0108, 4'b1111, 32'hDEAD_BEEF);
    run_access("st_w_wait", 0, 1, 2'b10, 0, 32'h108, 32'hDEAD_BEEF, 32'h0, 3, 4, 3, 0);

    // Faults: no bus activity, single fault cycle
    push_ev(2, 32'd1);
    run_access("mis_w", 1, 0, 2'b10, 0, 32'h102, 32'h0, 32'h0, 1, 1, 0, 0);
    push_ev(2, 32'd1);
    run_access("mis_h", 0, 1, 2'b01, 0, 32'h101, 32'h55, 32'h0, 1, 1, 0, 0);
    push_ev(2, 32'd3);
    run_access("size11", 1, 0, 2'b11, 0, 32'h100, 32'h0, 32'h0, 1, 1, 0, 0);
    push_ev(2, 32'd3);
    run_access("rd_wr", 1, 1, 2'b10, 0, 32'h100, 32'h0, 32'h0, 1, 1, 0, 0);
    push_ev(2, 32'd3);
    run_access("size11_mis", 1, 0, 2'b11, 0, 32'h103, 32'h0, 32'h0, 1, 1, 0, 0);

    // Timeout boundary with TIMEOUT_CYCLES = 8
    push_bus(1'b0, 32'h0000_0500, 4'b1111, 32'h0);
    push_ev(2, 32'd2);
    run_access("tmo", 1, 0, 2'b10, 0, 32'h500, 32'h0, 32'h0, 0, 9, 8, 0);
    push_bus(1'b1, 32'h0000_0504, 4'b0011, 32'h5A5A_5A5A);
    run_access("gnt_last", 0, 1, 2'b01, 0, 32'h504, 32'h0000_5A5A, 32'h0, 8, 9, 8, 0);

    // Asynchronous reset while waiting for read data
    push_bus(1'b0, 32'h0000_0400, 4'b1111, 32'h0);
    @(negedge clk);
    io.mem_read_in = 1'b1; io.mem_size_in = 2'b10; io.mem_sign_in = 1'b0;
    io.addr_in = 32'h400; io.wdata_in = '0; io.bus_rdata = 32'h55AA_55AA;
    @(negedge clk); #1;
    chk("rst_wait req phase", {31'b0, io.bus_req}, 32'd1);
    io.bus_gnt = 1'b1;
    @(negedge clk); #1;
    io.bus_gnt = 1'b0;
    chk("rst_wait stall", {31'b0, io.stall_out}, 32'd1);
    chk("rst_wait bus_req", {31'b0, io.bus_req}, 32'd0);
    #2;
    reset = 1'b1;
    io.mem_read_in = 1'b0;
    #1;
    chk("async rst stall", {31'b0, io.stall_out}, 32'd0);
    chk("async rst bus_req", {31'b0, io.bus_req}, 32'd0);
    chk("async rst rdata_out", io.rdata_out, 32'd0);
    chk("async rst rdata_valid", {31'b0, io.rdata_valid}, 32'd0);
    @(negedge clk); #1;
    reset = 1'b0;
    io.bus_rvalid = 1'b1;
    @(negedge clk); #1;
    io.bus_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("late rvalid stall", {31'b0, io.stall_out}, 32'd0);
      chk("late rvalid rdata_valid", {31'b0, io.rdata_valid}, 32'd0);
      chk("late rvalid rdata_out", io.rdata_out, 32'd0);
      @(negedge clk); #1;
    end

    repeat (2) @(negedge clk);
    chk("scoreboard drained", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
